// File: rtl/dmac_transfer_ctrl_if.sv
// System bus port of the DMAC transfer engine: per-word request/grant plus
// a single shared address with separate read and write data paths.
interface dmac_transfer_ctrl_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic              m_req;
    logic              m_grant;
    logic [ADDR_W-1:0] m_addr;
    logic              m_wr;
    logic [DATA_W-1:0] m_dout;
    logic [DATA_W-1:0] m_din;

    modport master (
        output m_req, m_addr, m_wr, m_dout,
        input  m_grant, m_din
    );

    modport slave (
        input  m_req, m_addr, m_wr, m_dout,
        output m_grant, m_din
    );
endinterface

// File: rtl/dmac_transfer_ctrl.sv
// DMAC sequencing engine: copies data_size words from src_addr to dest_addr,
// re-arbitrating the bus for every word (REQ -> READ -> CAPT -> WRITE).
module dmac_transfer_ctrl #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int SIZE_W = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 op_start,
    input  logic                 op_clear,
    input  logic [ADDR_W-1:0]    src_addr,
    input  logic [ADDR_W-1:0]    dest_addr,
    input  logic [SIZE_W-1:0]    data_size,
    dmac_transfer_ctrl_if.master bus,
    output logic                 busy,
    output logic                 done,
    output logic [SIZE_W-1:0]    remain_cnt
);

    typedef enum logic [2:0] {IDLE, REQ, READ, CAPT, WRITE, DONE} state_t;

    state_t            state, next_state;
    logic [ADDR_W-1:0] src_ptr;
    logic [ADDR_W-1:0] dst_ptr;
    logic [ADDR_W-1:0] addr_hold;
    logic [DATA_W-1:0] buffer;
    logic              release_gap;

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (op_start && !op_clear)
                         next_state = (data_size == '0) ? DONE : REQ;
            REQ:     if (bus.m_grant) next_state = READ;
            READ:    next_state = CAPT;
            CAPT:    next_state = WRITE;
            WRITE:   next_state = (remain_cnt <= SIZE_W'(1)) ? DONE : REQ;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
        if (op_clear && state != IDLE)
            next_state = IDLE;
    end

    // The first REQ cycle after a WRITE drops m_req so the arbiter sees a
    // release point per word; grant is still sampled there, so a held grant
    // keeps the 4-cycle word rate.
    always_comb begin
        bus.m_req  = 1'b0;
        bus.m_wr   = 1'b0;
        bus.m_addr = addr_hold;
        bus.m_dout = buffer;
        case (state)
            REQ:   bus.m_req = !release_gap;
            READ: begin
                bus.m_req  = 1'b1;
                bus.m_addr = src_ptr;
            end
            CAPT:  bus.m_req = 1'b1;
            WRITE: begin
                bus.m_req  = 1'b1;
                bus.m_wr   = 1'b1;
                bus.m_addr = dst_ptr;
            end
            default: ;
        endcase
        busy = (state != IDLE);
        done = (state == DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            src_ptr     <= '0;
            dst_ptr     <= '0;
            addr_hold   <= '0;
            buffer      <= '0;
            remain_cnt  <= '0;
            release_gap <= 1'b0;
        end else begin
            state       <= next_state;
            release_gap <= (state == WRITE) && (next_state == REQ);
            case (state)
                IDLE: if (op_start && !op_clear) begin
                    src_ptr    <= src_addr;
                    dst_ptr    <= dest_addr;
                    remain_cnt <= data_size;
                end
                READ: addr_hold <= src_ptr;
                CAPT: begin
                    buffer  <= bus.m_din;
                    src_ptr <= src_ptr + 1'b1;
                end
                WRITE: begin
                    // A write on the bus completes even if op_clear arrives now.
                    addr_hold <= dst_ptr;
                    dst_ptr   <= dst_ptr + 1'b1;
                    if (remain_cnt != '0)
                        remain_cnt <= remain_cnt - 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dmac_transfer_ctrl.sv
// Bench for dmac_transfer_ctrl: vector table, randomized transfers against a
// copy-semantics reference model, plus abort and reset-mid-transfer sequences.
module tb_dmac_transfer_ctrl;
    localparam int AW = 8;
    localparam int DW = 8;
    localparam int SW = 8;

    logic          clk = 1'b0;
    logic          reset, op_start, op_clear;
    logic [AW-1:0] src_addr, dest_addr;
    logic [SW-1:0] data_size;
    logic          busy, done;
    logic [SW-1:0] remain_cnt;

    dmac_transfer_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    dmac_transfer_ctrl #(.ADDR_W(AW), .DATA_W(DW), .SIZE_W(SW)) dut (
        .clk        (clk),
        .reset      (reset),
        .op_start   (op_start),
        .op_clear   (op_clear),
        .src_addr   (src_addr),
        .dest_addr  (dest_addr),
        .data_size  (data_size),
        .bus        (bus),
        .busy       (busy),
        .done       (done),
        .remain_cnt (remain_cnt)
    );

    always #5 clk = ~clk;

    int unsigned tests  = 0;
    int unsigned failed = 0;

    // Source memory is read-only: expected write data is simply mem[src+i].
    logic [DW-1:0] mem [256];
    always @(posedge clk) bus.m_din <= mem[bus.m_addr];

    // Arbiter: tied high, or grant after gdly low cycles of a raised request.
    bit          tied = 1'b1;
    int unsigned gdly = 0;
    int unsigned wcnt = 0;
    always @(negedge clk) begin
        if (tied) begin
            bus.m_grant = 1'b1;
            wcnt = 0;
        end else if (!bus.m_req) begin
            bus.m_grant = 1'b0;
            wcnt = 0;
        end else if (wcnt >= gdly) begin
            bus.m_grant = 1'b1;
        end else begin
            bus.m_grant = 1'b0;
            wcnt++;
        end
    end

    // Bus monitor: monotonic logs, only ever read by the stimulus process.
    logic [AW-1:0] wr_a [$];
    logic [DW-1:0] wr_d [$];
    int unsigned   gap_q [$];
    int unsigned   req_cycles = 0;
    int unsigned   done_cnt   = 0;
    int unsigned   gap_len    = 0;
    always @(negedge clk) begin
        if (bus.m_req) req_cycles++;
        if (bus.m_req && bus.m_wr) begin
            wr_a.push_back(bus.m_addr);
            wr_d.push_back(bus.m_dout);
        end
        if (done) done_cnt++;
        if (!busy) gap_len = 0;
        else if (bus.m_req) begin
            if (gap_len > 0) gap_q.push_back(gap_len);
            gap_len = 0;
        end else if (!done) gap_len++;
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic run_xfer(input logic [7:0] s, input logic [7:0] d, input logic [7:0] n,
                            input int unsigned g, input int unsigned lat_exp,
                            input int unsigned req_exp, input string tag);
        int unsigned w0, r0, d0, g0, lat, bad;
        logic [7:0] ea, sa;
        @(negedge clk);
        tied = (g == 0);
        gdly = g;
        w0 = wr_a.size(); r0 = req_cycles; d0 = done_cnt; g0 = gap_q.size();
        src_addr = s; dest_addr = d; data_size = n; op_start = 1'b1;
        @(negedge clk);
        op_start = 1'b0;
        check({tag, "_busy_rise"}, busy, 1);
        lat = 1;
        while (!done && lat < 3000) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_latency"}, lat, lat_exp);
        check({tag, "_busy_at_done"}, busy, 1);
        @(negedge clk);
        check({tag, "_busy_after"}, busy, 0);
        check({tag, "_done_pulse"}, done, 0);
        check({tag, "_remain"}, remain_cnt, 0);
        check({tag, "_done_count"}, done_cnt - d0, 1);
        check({tag, "_req_cycles"}, req_cycles - r0, req_exp);
        check({tag, "_write_count"}, wr_a.size() - w0, n);
        check({tag, "_gap_count"}, gap_q.size() - g0, (n > 0) ? n - 1 : 0);
        bad = 0;
        for (int unsigned i = g0; i < gap_q.size(); i++)
            if (gap_q[i] != 1) bad++;
        check({tag, "_gap_len"}, bad, 0);
        for (int unsigned i = 0; i < n && w0 + i < wr_a.size(); i++) begin
            ea = d + 8'(i);
            sa = s + 8'(i);
            check($sformatf("%s_waddr%0d", tag, i), wr_a[w0+i], ea);
            check($sformatf("%s_wdata%0d", tag, i), wr_d[w0+i], mem[sa]);
        end
    endtask

    typedef struct {
        logic [7:0]  src;
        logic [7:0]  dst;
        logic [7:0]  size;
        int unsigned gdly;
        int unsigned lat;
        int unsigned reqc;
    } vec_t;

    vec_t vecs [7];

    initial begin
        int unsigned bad, nw, k, g, n, w0;
        logic [7:0] s, d;

        vecs[0] = '{8'h10, 8'h40, 8'd3,   0, 13,   10};
        vecs[1] = '{8'h22, 8'h33, 8'd0,   0, 1,    0};
        vecs[2] = '{8'h50, 8'h90, 8'd2,   5, 20,   18};
        vecs[3] = '{8'hFE, 8'hFF, 8'd3,   0, 13,   10};
        vecs[4] = '{8'h07, 8'hC0, 8'd1,   0, 5,    4};
        vecs[5] = '{8'h00, 8'h80, 8'd255, 0, 1021, 766};
        vecs[6] = '{8'hA0, 8'h05, 8'd3,   2, 21,   18};

        for (int i = 0; i < 256; i++) mem[i] = 8'(i * 37 + 11);
        mem[8'h10] = 8'hA1; mem[8'h11] = 8'hB2; mem[8'h12] = 8'hC3;

        reset = 1'b1; op_start = 1'b0; op_clear = 1'b0;
        src_addr = '0; dest_addr = '0; data_size = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_m_req", bus.m_req, 0);
        check("rst_m_wr", bus.m_wr, 0);
        check("rst_m_addr", bus.m_addr, 0);
        check("rst_m_dout", bus.m_dout, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_remain", remain_cnt, 0);

        for (int i = 0; i < 7; i++)
            run_xfer(vecs[i].src, vecs[i].dst, vecs[i].size, vecs[i].gdly,
                     vecs[i].lat, vecs[i].reqc, $sformatf("vec%0d", i));

        for (int i = 0; i < 16; i++) begin
            s = 8'($urandom);
            d = 8'($urandom);
            n = $urandom_range(1, 10);
            g = $urandom_range(0, 3);
            run_xfer(s, d, 8'(n), g,
                     (g == 0) ? 1 + 4 * n : 1 + n * (g + 4) + (n - 1),
                     (g == 0) ? 3 * n + 1 : n * (g + 4),
                     $sformatf("rnd%0d", i));
        end

        // Abort after the second write, with a competing start in the same cycle.
        @(negedge clk);
        tied = 1'b1;
        w0 = wr_a.size();
        src_addr = 8'h20; dest_addr = 8'h60; data_size = 8'd5; op_start = 1'b1;
        @(negedge clk);
        op_start = 1'b0;
        nw = 0; k = 0;
        while (nw < 2 && k < 100) begin
            @(negedge clk);
            k++;
            if (bus.m_wr) nw++;
        end
        check("abort_two_writes_seen", nw, 2);
        @(negedge clk);
        op_clear = 1'b1; op_start = 1'b1;
        src_addr = 8'h00; data_size = 8'd9;
        @(negedge clk);
        op_clear = 1'b0; op_start = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_m_req", bus.m_req, 0);
        check("abort_m_wr", bus.m_wr, 0);
        check("abort_done", done, 0);
        check("abort_remain", remain_cnt, 3);
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (busy || bus.m_req || done) bad++;
        end
        check("abort_quiet", bad, 0);
        check("abort_remain_held", remain_cnt, 3);
        check("abort_write_count", wr_a.size() - w0, 2);

        // Reset asserted while the controller sits in CAPT.
        @(negedge clk);
        src_addr = 8'h30; dest_addr = 8'h70; data_size = 8'd4; op_start = 1'b1;
        @(negedge clk);
        op_start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("capt_req", bus.m_req, 1);
        check("capt_not_write", bus.m_wr, 0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("mid_rst_m_req", bus.m_req, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_remain", remain_cnt, 0);
        check("mid_rst_m_addr", bus.m_addr, 0);
        check("mid_rst_done", done, 0);
        run_xfer(8'h30, 8'h70, 8'd4, 0, 17, 13, "post_reset");

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end
endmodule
